// File: rtl/tiny_cpu_sequencer.sv
// TinyCPU control sequencer: steps each instruction through FETCH/DECODE/EXECUTE,
// drives the accumulator-source mux selects and the datapath load/increment strobes.
module tiny_cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] instr_in,
    input  logic       zero,
    output logic       select0,
    output logic       select1,
    output logic       select2,
    output logic       load_acc,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       mem_read,
    output logic [4:0] operand,
    output logic       halted,
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_LDI  = 3'd5,
        OP_JZ   = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    state_t     state;
    state_t     state_nxt;
    opcode_t    opcode;
    logic [2:0] sel;
    logic       fetch_go;

    // JZ and HALT both route source h (the zero flag); the rest map straight through.
    function automatic logic [2:0] src_sel(input opcode_t op);
        if (op == OP_JZ || op == OP_HALT)
            return 3'b111;
        else
            return op;
    endfunction

    // Held off during reset so the fetch strobes honour their reset value even with run high.
    assign fetch_go = run & ~rst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode      <= OP_LOAD;
            operand     <= 5'd0;
            sel         <= 3'b000;
            instr_count <= 8'd0;
        end else begin
            if (state == S_FETCH && run) begin
                opcode  <= opcode_t'(instr_in[7:5]);
                operand <= instr_in[4:0];
            end
            if (state == S_DECODE)
                sel <= src_sel(opcode);
            if (state == S_EXECUTE)
                instr_count <= instr_count + 8'd1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load_acc  = 1'b0;
        load_ir   = 1'b0;
        inc_pc    = 1'b0;
        load_pc   = 1'b0;
        mem_read  = 1'b0;
        halted    = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (fetch_go) begin
                    mem_read  = 1'b1;
                    load_ir   = 1'b1;
                    inc_pc    = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                mem_read  = (opcode <= OP_OR);
                state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                load_acc  = (opcode <= OP_LDI);
                load_pc   = (opcode == OP_JZ) && zero;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign select0 = sel[0];
    assign select1 = sel[1];
    assign select2 = sel[2];

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Directed scoreboard bench for tiny_cpu_sequencer: expected output vectors are
// queued per cycle as stimulus is driven and compared when the cycle is sampled.
module tb_tiny_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] instr_in;
    logic       zero;
    logic       select0, select1, select2;
    logic       load_acc, load_ir, inc_pc, load_pc, mem_read;
    logic [4:0] operand;
    logic       halted;
    logic [7:0] instr_count;

    typedef struct packed {
        logic [2:0] sel;
        logic       acc;
        logic       ir;
        logic       inc;
        logic       pc;
        logic       mr;
        logic [4:0] op;
        logic       halt;
        logic [7:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state tracked by the bench from the instructions it issues.
    logic [2:0] m_sel;
    logic [4:0] m_op;
    logic [7:0] m_cnt;

    tiny_cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instr_in    (instr_in),
        .zero        (zero),
        .select0     (select0),
        .select1     (select1),
        .select2     (select2),
        .load_acc    (load_acc),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .mem_read    (mem_read),
        .operand     (operand),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [2:0] s, input logic acc, input logic ir,
                                input logic inc, input logic pc, input logic mr,
                                input logic [4:0] op, input logic h, input logic [7:0] c);
        obs_t e;
        e.sel  = s;
        e.acc  = acc;
        e.ir   = ir;
        e.inc  = inc;
        e.pc   = pc;
        e.mr   = mr;
        e.op   = op;
        e.halt = h;
        e.cnt  = c;
        return e;
    endfunction

    function automatic obs_t observe();
        return mk({select2, select1, select0}, load_acc, load_ir, inc_pc, load_pc,
                  mem_read, operand, halted, instr_count);
    endfunction

    task automatic compare_front(input string tag);
        obs_t e;
        obs_t o;
        e = sb.pop_front();
        o = observe();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed sel=%b acc=%b ir=%b inc=%b pc=%b mr=%b op=%0d halt=%b cnt=%0d expected sel=%b acc=%b ir=%b inc=%b pc=%b mr=%b op=%0d halt=%b cnt=%0d",
                   tag, o.sel, o.acc, o.ir, o.inc, o.pc, o.mr, o.op, o.halt, o.cnt,
                   e.sel, e.acc, e.ir, e.inc, e.pc, e.mr, e.op, e.halt, e.cnt);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, compare before the next rising edge.
    task automatic cyc(input string tag, input logic r, input logic [7:0] ins,
                       input logic z, input obs_t e);
        @(negedge clk);
        run      = r;
        instr_in = ins;
        zero     = z;
        sb.push_back(e);
        #2;
        compare_front(tag);
    endtask

    // One non-HALT instruction; run is dropped and instr_in/zero scrambled outside
    // the cycles where they are meant to be sampled.
    task automatic run_instr(input string tag, input logic [7:0] ins, input logic z);
        logic [2:0] op;
        op = ins[7:5];
        cyc({tag, ":fetch"}, 1'b1, ins, ~z, mk(m_sel, 0, 1, 1, 0, 1, m_op, 0, m_cnt));
        m_op = ins[4:0];
        cyc({tag, ":decode"}, 1'b0, ~ins, ~z, mk(m_sel, 0, 0, 0, 0, (op <= 3'd4), m_op, 0, m_cnt));
        m_sel = (op >= 3'd6) ? 3'b111 : op;
        cyc({tag, ":exec"}, 1'b0, ~ins, z,
            mk(m_sel, (op <= 3'd5), 0, 0, (op == 3'd6) && z, 0, m_op, 0, m_cnt));
        m_cnt = m_cnt + 8'd1;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear with no edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        run = 1'b1;
        #1 rst = 1'b1;
        sb.push_back(mk(3'b000, 0, 0, 0, 0, 0, 5'd0, 0, 8'd0));
        #1 compare_front(tag);
        run = 1'b0;
        rst = 1'b0;
        m_sel = 3'b000;
        m_op  = 5'd0;
        m_cnt = 8'd0;
    endtask

    initial begin
        rst      = 1'b1;
        run      = 1'b1;
        instr_in = 8'h3F;
        zero     = 1'b0;
        m_sel    = 3'b000;
        m_op     = 5'd0;
        m_cnt    = 8'd0;

        // Reset state, with run high to show the fetch strobes stay low under reset.
        cyc("reset", 1'b1, 8'h3F, 1'b0, mk(3'b000, 0, 0, 0, 0, 0, 5'd0, 0, 8'd0));
        run = 1'b0;
        rst = 1'b0;

        run_instr("add3", 8'b001_00011, 1'b0);
        run_instr("ldi9", 8'b101_01001, 1'b0);
        run_instr("jz14_z1", 8'b110_01110, 1'b1);
        run_instr("jz14_z0", 8'b110_01110, 1'b0);

        for (int i = 0; i < 5; i++)
            cyc("stall", 1'b0, 8'h21, 1'b1, mk(m_sel, 0, 0, 0, 0, 0, m_op, 0, m_cnt));
        run_instr("sub5", 8'b010_00101, 1'b0);

        // HALT: fetch, decode, then parked with no strobes and no count change.
        cyc("halt:fetch", 1'b1, 8'hE0, 1'b0, mk(m_sel, 0, 1, 1, 0, 1, m_op, 0, m_cnt));
        m_op = 5'd0;
        cyc("halt:decode", 1'b1, 8'h21, 1'b0, mk(m_sel, 0, 0, 0, 0, 0, m_op, 0, m_cnt));
        m_sel = 3'b111;
        for (int i = 0; i < 10; i++)
            cyc("halted", 1'b1, 8'h21, 1'b1, mk(m_sel, 0, 0, 0, 0, 0, m_op, 1, m_cnt));

        pulse_reset("reset_from_halt");
        cyc("idle_after_reset", 1'b0, 8'h21, 1'b0, mk(3'b000, 0, 0, 0, 0, 0, 5'd0, 0, 8'd0));

        run_instr("load7", 8'b000_00111, 1'b0);
        run_instr("and31", 8'b011_11111, 1'b1);
        run_instr("or16", 8'b100_10000, 1'b0);

        // Reset asserted mid-EXECUTE of an ADD.
        cyc("mid:fetch", 1'b1, 8'b001_00110, 1'b0, mk(m_sel, 0, 1, 1, 0, 1, m_op, 0, m_cnt));
        m_op = 5'd6;
        cyc("mid:decode", 1'b0, 8'h00, 1'b0, mk(m_sel, 0, 0, 0, 0, 1, m_op, 0, m_cnt));
        m_sel = 3'b001;
        cyc("mid:exec", 1'b0, 8'h00, 1'b0, mk(m_sel, 1, 0, 0, 0, 0, m_op, 0, m_cnt));
        #1 rst = 1'b1;
        sb.push_back(mk(3'b000, 0, 0, 0, 0, 0, 5'd0, 0, 8'd0));
        #1 compare_front("mid:reset_async");
        @(negedge clk);
        rst = 1'b0;
        m_sel = 3'b000;
        m_op  = 5'd0;
        m_cnt = 8'd0;
        cyc("mid:resume_idle", 1'b0, 8'h21, 1'b0, mk(3'b000, 0, 0, 0, 0, 0, 5'd0, 0, 8'd0));

        // 256 retired instructions bring the counter back to zero.
        for (int i = 0; i < 256; i++)
            run_instr("wrap_ldi", {3'b101, 5'($urandom_range(31))}, 1'($urandom_range(1)));
        cyc("wrap_count", 1'b0, 8'h21, 1'b0, mk(m_sel, 0, 0, 0, 0, 0, m_op, 0, 8'h00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
